unique_list_serializer: RTL and testbench
=========================================

Name: unique_list_serializer

Overview:
- Sits directly downstream of the last-N-unique tracker and consumes its NUM-entry list and per-entry valid mask.
- On a snapshot request, it captures the list into shadow registers. It then emits only the valid entries, one per handshake, over a valid/ready stream.
- Entry 0 is the most recently inserted value. Emission order is ascending index, so the newest entry goes out first.
- Requests arriving while a snapshot is still draining are counted as drops.

Parameters:
- WIDTH, 8, bit width of one list entry.
- NUM, 4, number of list entries; must be at least 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk_in  input  1  single clock; all state updates on the rising edge.
- rst_n_in  input  1  reset, asynchronous and active-low.
- list_in  input  [NUM-1:0][WIDTH-1:0]  entry list from the tracker; entry 0 is the newest.
- list_valid_in  input  NUM  per-entry valid mask from the tracker.
- snap_in  input  1  snapshot request, sampled every cycle.
- dout  output  WIDTH  current emitted entry.
- dout_idx  output  $clog2(NUM)  list index of the current entry.
- dout_valid  output  1  stream valid.
- dout_last  output  1  high with the final entry of a snapshot.
- dout_ready  input  1  downstream ready.
- empty_out  output  1  one-cycle pulse when the captured snapshot has no valid entries.
- busy_out  output  1  high while in SEND.
- drop_cnt  output  CNT_W  number of rejected snap_in requests.

Behaviour:
- Reset (asynchronous, rst_n_in=0):
  - state=IDLE.
  - dout, dout_idx, dout_valid, dout_last, empty_out, busy_out, drop_cnt and the shadow mask all go to 0 immediately, without waiting for a clock edge.
  - Deassertion takes effect at the next rising edge.
- States: IDLE and SEND only. All outputs are registered or decoded from registered state; nothing is combinational from the inputs.
- IDLE with snap_in=1 at edge N:
  - Latch list_in into the shadow list and list_valid_in into the shadow mask.
  - Mask==0: stay IDLE; empty_out=1 during cycle N+1 only.
  - Mask!=0: state=SEND; ptr=lowest set bit; dout_valid=1 from cycle N+1 (latency 1).
- SEND outputs:
  - dout=shadow[ptr], dout_idx=ptr.
  - dout_last=1 exactly when the shadow mask has no set bit above ptr.
- Handshake rules:
  - When dout_valid=1 and dout_ready=0, dout, dout_idx, dout_last and dout_valid hold stable.
  - dout_valid never drops without a transfer.
  - dout_ready is don't-care while dout_valid=0.
- On transfer (dout_valid & dout_ready at an edge):
  - Not last: ptr advances to the next higher set bit in the mask, skipping holes, so sparse masks such as 4'b1010 are legal.
  - Last: state=IDLE; dout_valid=0 and busy_out=0 from the next cycle.
- Throughput is one entry per cycle while dout_ready stays high. A full NUM-entry snapshot occupies NUM cycles.
- Isolation: the shadow copy is immune to list_in and list_valid_in changes after capture.
- snap_in=1 while in SEND is rejected and increments drop_cnt, which saturates at 2^CNT_W-1. This includes the cycle of the final transfer: back-to-back acceptance is not supported, and the next snapshot is accepted from IDLE one cycle later.
- snap_in in IDLE never increments drop_cnt.
- Reset mid-SEND aborts the stream: dout_valid falls asynchronously with no dout_last, and the partial snapshot is discarded.
- busy_out=1 exactly when state=SEND.

Test Plan:
- Basic newest-first drain: WIDTH=8, NUM=4. Pulse snap_in with list={0x44,0x33,0x22,0x11} (entry3..0) and mask=4'b1111; dout_ready=1. Required: starting the next cycle, four consecutive beats with dout=0x11,0x22,0x33,0x44 and dout_idx=0..3; dout_last=1 only on 0x44; busy_out drops after the fourth beat.
- Backpressure: same snapshot, with dout_ready=0 for 3 cycles before each beat. Required: dout, dout_idx and dout_last hold stable while stalled; exactly 4 transfers occur; no value is duplicated or skipped.
- Sparse mask and empty snapshot: mask=4'b0101 with entries {0xAA,0xBB,0xCC,0xDD}. Required: two beats, 0xDD (idx0) then 0xBB (idx2, last). Then snap with mask=0. Required: empty_out high for exactly one cycle, dout_valid stays 0, busy_out stays 0.
- Drops and saturation: during a 4-beat drain, pulse snap_in 3 times, including the cycle of the last transfer. Required: drop_cnt=3 and the snapshot contents are unchanged. Then force 300 rejected requests with CNT_W=8. Required: drop_cnt=255.
- Capture isolation and async reset: change list_in every cycle during a drain. Required: dout shows only the captured values. Then assert rst_n_in low mid-beat, between clock edges. Required: dout_valid, busy_out and drop_cnt read 0 before the next edge. After release, a new snap_in drains normally.

Source files
------------

// File: rtl/unique_list_serializer.sv
// Captures the tracker's entry list on request and streams its valid entries newest-first
// over a valid/ready interface, counting requests that arrive while a snapshot is draining.
module unique_list_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NUM   = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [NUM-1:0][WIDTH-1:0]     list_in,
  input  logic [NUM-1:0]                list_valid_in,
  input  logic                          snap_in,
  output logic [WIDTH-1:0]              dout,
  output logic [$clog2(NUM)-1:0]        dout_idx,
  output logic                          dout_valid,
  output logic                          dout_last,
  input  logic                          dout_ready,
  output logic                          empty_out,
  output logic                          busy_out,
  output logic [CNT_W-1:0]              drop_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state;
  logic [NUM-1:0][WIDTH-1:0] sh_list;
  logic [NUM-1:0]            sh_mask;

  logic [IDX_W-1:0]          first_c;
  logic                      first_last_c;
  logic [IDX_W-1:0]          nxt_c;
  logic                      nxt_last_c;

  // Index of the lowest set bit at or above lo (0 when none).
  function automatic logic [IDX_W-1:0] lowest_from(input logic [NUM-1:0] m, input int lo);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) r = IDX_W'(i);
    end
    return r;
  endfunction

  // True when any bit strictly above idx is set.
  function automatic logic any_above(input logic [NUM-1:0] m, input int idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (m[i] && (i > idx)) r = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    first_c      = lowest_from(list_valid_in, 0);
    first_last_c = !any_above(list_valid_in, int'(first_c));
    nxt_c        = lowest_from(sh_mask, int'(dout_idx) + 1);
    nxt_last_c   = !any_above(sh_mask, int'(nxt_c));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      sh_list    <= '0;
      sh_mask    <= '0;
      dout       <= '0;
      dout_idx   <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      empty_out  <= 1'b0;
      busy_out   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      empty_out <= 1'b0;
      case (state)
        IDLE: begin
          if (snap_in) begin
            sh_list <= list_in;
            sh_mask <= list_valid_in;
            if (list_valid_in == '0) begin
              empty_out <= 1'b1;
            end else begin
              state      <= SEND;
              busy_out   <= 1'b1;
              dout_valid <= 1'b1;
              dout       <= list_in[first_c];
              dout_idx   <= first_c;
              dout_last  <= first_last_c;
            end
          end
        end
        SEND: begin
          // Requests during a drain, including its final transfer, are rejected.
          if (snap_in && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
          if (dout_ready) begin
            if (dout_last) begin
              state      <= IDLE;
              busy_out   <= 1'b0;
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
            end else begin
              dout      <= sh_list[nxt_c];
              dout_idx  <= nxt_c;
              dout_last <= nxt_last_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unique_list_serializer.sv
// Randomized and directed bench for unique_list_serializer against a queue-based reference model.
module tb_unique_list_serializer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NUM   = 4;
  localparam int unsigned CNT_W = 8;

  logic                      clk_in;
  logic                      rst_n_in;
  logic [NUM-1:0][WIDTH-1:0] list_in;
  logic [NUM-1:0]            list_valid_in;
  logic                      snap_in;
  logic [WIDTH-1:0]          dout;
  logic [1:0]                dout_idx;
  logic                      dout_valid;
  logic                      dout_last;
  logic                      dout_ready;
  logic                      empty_out;
  logic                      busy_out;
  logic [CNT_W-1:0]          drop_cnt;

  int checks = 0;
  int errors = 0;

  unique_list_serializer #(.WIDTH(WIDTH), .NUM(NUM), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .list_in(list_in), .list_valid_in(list_valid_in),
    .snap_in(snap_in), .dout(dout), .dout_idx(dout_idx), .dout_valid(dout_valid),
    .dout_last(dout_last), .dout_ready(dout_ready), .empty_out(empty_out),
    .busy_out(busy_out), .drop_cnt(drop_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending beats of the current snapshot, head is the beat on the bus.
  typedef struct {
    logic [WIDTH-1:0] v;
    logic [1:0]       i;
    logic             l;
  } beat_t;

  beat_t mq[$];
  int    mdrop;
  logic  mempty;

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mq.delete();
      mdrop  = 0;
      mempty = 1'b0;
    end else begin
      mempty = 1'b0;
      if (mq.size() > 0) begin
        if (snap_in && mdrop < 255) mdrop++;
        if (dout_ready) void'(mq.pop_front());
      end else if (snap_in) begin
        for (int k = 0; k < NUM; k++) begin
          if (list_valid_in[k]) mq.push_back('{v: list_in[k], i: 2'(k), l: 1'b0});
        end
        if (mq.size() == 0) mempty = 1'b1;
        else mq[mq.size()-1].l = 1'b1;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk_in) begin
    chk("dout_valid", 32'(dout_valid), 32'(mq.size() > 0));
    chk("busy_out", 32'(busy_out), 32'(mq.size() > 0));
    chk("empty_out", 32'(empty_out), 32'(mempty));
    chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
    if (mq.size() > 0) begin
      chk("dout", 32'(dout), 32'(mq[0].v));
      chk("dout_idx", 32'(dout_idx), 32'(mq[0].i));
      chk("dout_last", 32'(dout_last), 32'(mq[0].l));
    end
  end

  // Log of completed transfers as {idx, data}.
  logic [9:0] lg[$];
  always @(posedge clk_in) begin
    if (rst_n_in && dout_valid && dout_ready) lg.push_back({dout_idx, dout});
  end

  task automatic cyc(input logic s, input logic r);
    @(negedge clk_in);
    snap_in    = s;
    dout_ready = r;
  endtask

  task automatic cyc_rand(input logic r);
    @(negedge clk_in);
    snap_in       = 1'b0;
    dout_ready    = r;
    list_in       = {$urandom, $urandom};
    list_valid_in = 4'($urandom);
  endtask

  task automatic wait_idle(input logic r);
    int n;
    n = 0;
    do begin
      cyc(1'b0, r);
      n++;
    end while (dout_valid && n < 200);
    if (n >= 200) chk("drain_timeout", 32'(dout_valid), 32'd0);
  endtask

  task automatic chk_log(input int n, input logic [9:0] e0, input logic [9:0] e1,
                         input logic [9:0] e2, input logic [9:0] e3);
    logic [9:0] e[4];
    e = '{e0, e1, e2, e3};
    chk("log_len", 32'(lg.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (k < lg.size()) chk("log_beat", 32'(lg[k]), 32'(e[k]));
    end
  endtask

  initial begin
    int ecount;
    rst_n_in      = 1'b0;
    snap_in       = 1'b0;
    dout_ready    = 1'b0;
    list_in       = '0;
    list_valid_in = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_empty", 32'(empty_out), 32'd0);
    rst_n_in = 1'b1;

    // Full drain, newest first.
    lg.delete();
    list_in = {8'h44, 8'h33, 8'h22, 8'h11};
    list_valid_in = 4'b1111;
    cyc(1'b1, 1'b1);
    wait_idle(1'b1);
    chk_log(4, {2'd0, 8'h11}, {2'd1, 8'h22}, {2'd2, 8'h33}, {2'd3, 8'h44});
    chk("t1_busy", 32'(busy_out), 32'd0);

    // Backpressure: three stall cycles before every beat.
    lg.delete();
    cyc(1'b1, 1'b0);
    for (int b = 0; b < 4; b++) begin
      repeat (3) cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
    end
    cyc(1'b0, 1'b1);
    chk_log(4, {2'd0, 8'h11}, {2'd1, 8'h22}, {2'd2, 8'h33}, {2'd3, 8'h44});
    chk("t2_busy", 32'(busy_out), 32'd0);

    // Sparse mask, then an empty snapshot.
    lg.delete();
    list_in = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    list_valid_in = 4'b0101;
    cyc(1'b1, 1'b1);
    wait_idle(1'b1);
    chk_log(2, {2'd0, 8'hDD}, {2'd2, 8'hBB}, 10'd0, 10'd0);
    list_valid_in = 4'b0000;
    cyc(1'b1, 1'b1);
    ecount = 0;
    repeat (4) begin
      cyc(1'b0, 1'b1);
      if (empty_out) ecount++;
    end
    chk("empty_pulses", 32'(ecount), 32'd1);

    // Drops during a drain, one on the final transfer.
    lg.delete();
    list_in = {8'h44, 8'h33, 8'h22, 8'h11};
    list_valid_in = 4'b1111;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("drop3", 32'(drop_cnt), 32'd3);
    chk("t4_busy", 32'(busy_out), 32'd0);
    chk_log(4, {2'd0, 8'h11}, {2'd1, 8'h22}, {2'd2, 8'h33}, {2'd3, 8'h44});

    // Saturation of the drop counter.
    cyc(1'b1, 1'b0);
    repeat (300) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    wait_idle(1'b1);

    // Capture isolation: inputs scrambled every cycle after the capture edge.
    lg.delete();
    list_in = {8'h9A, 8'h78, 8'h56, 8'h34};
    list_valid_in = 4'b1111;
    cyc(1'b1, 1'b1);
    repeat (6) cyc_rand(1'($urandom));
    wait_idle(1'b1);
    chk_log(4, {2'd0, 8'h34}, {2'd1, 8'h56}, {2'd2, 8'h78}, {2'd3, 8'h9A});

    // Random traffic against the model.
    repeat (600) begin
      @(negedge clk_in);
      snap_in       = ($urandom % 4) == 0;
      dout_ready    = ($urandom % 4) != 0;
      list_in       = {$urandom, $urandom};
      list_valid_in = 4'($urandom);
    end
    wait_idle(1'b1);

    // Asynchronous reset mid-beat.
    list_in = {8'h04, 8'h03, 8'h02, 8'h01};
    list_valid_in = 4'b1111;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("pre_rst_valid", 32'(dout_valid), 32'd1);
    @(posedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("arst_valid", 32'(dout_valid), 32'd0);
    chk("arst_busy", 32'(busy_out), 32'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    chk("arst_last", 32'(dout_last), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    lg.delete();
    list_in = {8'hE4, 8'hE3, 8'hE2, 8'hE1};
    list_valid_in = 4'b1110;
    cyc(1'b1, 1'b1);
    wait_idle(1'b1);
    chk_log(3, {2'd1, 8'hE2}, {2'd2, 8'hE3}, {2'd3, 8'hE4}, 10'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
